multi_clk_gen: RTL and testbench
================================

Name: multi_clk_gen

Overview:
- Parametrised successor to the single fixed-ratio divider in the audio/PCM path.
- Generates NCH independent divided clocks from one system clock, e.g. mic bit clock, sample-rate strobe and FIFO drain strobe.
- Each channel has a runtime-programmable divisor, applied glitch-free at a period boundary, plus an enable.
- A global sync restarts all channels phase-aligned; each channel also emits a one-cycle rising-edge tick for use as a clock enable.

Parameters:
- NCH, 2, number of output channels (1..8).
- CW, 32, divisor/counter width in bits.
- DEF_DIV, 1666, reset divisor for every channel; half-period = DEF_DIV+1 clk cycles.
- CHW, 1, channel index width, set to max(1, clog2(NCH)).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- en  in  NCH  per-channel run enable.
- sync  in  1  single-cycle pulse; restarts all channels aligned.
- cfg_valid  in  1  divisor write request.
- cfg_ready  out  1  write may be accepted this cycle.
- cfg_ch  in  CHW  target channel.
- cfg_div  in  CW  new divisor value.
- clkout  out  NCH  divided clocks, registered.
- tick  out  NCH  one-cycle pulse on each clkout rising edge, registered.

Behaviour:
- Per-channel state: cnt[CW], act_div[CW], pend_div[CW], pend_vld.
- Reset (all values, next edge): clkout=0, tick=0, cnt=act_div=DEF_DIV, pend_vld=0.
- Half-period = act_div+1 cycles; full period = 2*(act_div+1).
  - cfg_div=0 gives a toggle every cycle (period 2).
  - Maximum cfg_div is 2^CW-1; there is no overflow path.
- Running channel (en=1, sync=0):
  - cnt!=0: cnt<=cnt-1.
  - cnt==0: clkout<=~clkout.
    - If pend_vld=1: act_div<=pend_div, cnt<=pend_div, pend_vld<=0.
    - Otherwise: cnt<=act_div.
- tick<=1 only on the edge where clkout goes 0->1; otherwise tick<=0.
  - tick is therefore high during the first cycle of each clkout high phase.
- Disabled channel (en=0):
  - Next edge: clkout<=0, tick<=0.
  - If pend_vld=1: act_div<=pend_div, pend_vld<=0.
  - cnt<=(pend_vld ? pend_div : act_div).
- Re-enable: the first rise occurs act_div+1 cycles after the first cycle with en=1.
- sync=1 (priority over the zero-count toggle, for every channel regardless of en):
  - clkout<=0, tick<=0.
  - Any pending divisor is promoted; cnt<=the resulting act_div.
  - All enabled channels with equal divisors are then bit-identical.
- Config handshake:
  - cfg_ready = ~pend_vld[cfg_ch] (combinational on cfg_ch); a write is accepted when cfg_valid && cfg_ready.
  - Accept: pend_div[cfg_ch]<=cfg_div, pend_vld[cfg_ch]<=1.
  - cfg_ch>=NCH: cfg_ready=1, the write is accepted and dropped, no state change.
  - A second write to the same channel stalls (cfg_ready=0) until the pending value is promoted.
- Simultaneous write and promotion on the same channel: the promotion uses the old pend_div; the new write is not accepted that cycle because cfg_ready=0.
- Reset mid-period or with a write pending: everything returns to reset values and the pending write is lost.
- Never use clkout as a clock inside the design; downstream logic uses tick as a clock enable on clk.

Test Plan:
- Reset release, DEF_DIV=3, en=2'b11, no cfg:
  - clkout[0] first rises 4 cycles after reset deasserts; period 8, 50% duty.
  - tick[0] is a 1-cycle pulse every 8 cycles, coincident with the first high cycle.
- Mid-period write cfg_ch=0, cfg_div=1:
  - Current half-period completes with length 4; subsequent half-periods have length 2.
  - cfg_ready(ch0)=0 from the accept until promotion, then 1.
  - Channel 1 is unaffected.
- cfg_div=0 on ch1:
  - clkout[1] toggles every cycle after promotion.
  - tick[1] is high every 2nd cycle.
- en[0] dropped for 5 cycles, then raised:
  - clkout[0]=0 and tick[0]=0 on the next edge and while disabled.
  - First rise occurs act_div+1 cycles after re-enable.
- ch0 div=3, ch1 div=1, free-running, sync pulse:
  - Both clkouts = 0 next cycle.
  - Rises at sync+4 (ch0) and sync+2 (ch1); ch1 rises exactly twice per ch0 period thereafter.
- Boundary cases:
  - cfg_ch=3 with NCH=2: accepted, no effect.
  - reset asserted with pend_vld=1: pend_vld=0 and DEF_DIV restored.

Source files
------------

// File: rtl/multi_clk_gen.sv
// NCH-channel programmable clock divider. Every channel produces a registered divided
// clock and a one-cycle tick on its rising edge. All logic runs on clk.
module multi_clk_gen #(
    parameter int NCH     = 2,
    parameter int CW      = 32,
    parameter int DEF_DIV = 1666,
    parameter int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] en,
    input  logic           sync,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [CW-1:0]  cfg_div,
    output logic [NCH-1:0] clkout,
    output logic [NCH-1:0] tick
);

    localparam logic [CW-1:0] DEF_DIV_V = CW'(DEF_DIV);

    // Per-channel state: down-counter, active divisor, one-deep pending divisor.
    logic [CW-1:0]  cnt_q      [NCH];
    logic [CW-1:0]  cnt_d      [NCH];
    logic [CW-1:0]  act_q      [NCH];
    logic [CW-1:0]  act_d      [NCH];
    logic [CW-1:0]  pend_q     [NCH];
    logic [CW-1:0]  pend_d     [NCH];
    logic [CW-1:0]  reload_div [NCH];
    logic [NCH-1:0] pend_vld_q;
    logic [NCH-1:0] pend_vld_d;
    logic [NCH-1:0] clkout_d;
    logic [NCH-1:0] tick_d;
    logic [NCH-1:0] cfg_hit;

    // Config handshake: a write transfers on the clk edge where cfg_valid && cfg_ready.
    // cfg_ready depends only on cfg_ch and that channel's pending flag, never on
    // cfg_valid; a channel that already holds a pending divisor refuses until promotion.
    // Writes to channel indices >= NCH are always ready and discarded.
    always_comb begin
        cfg_ready = 1'b1;
        cfg_hit   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (int'(cfg_ch) == i) begin
                cfg_ready  = ~pend_vld_q[i];
                cfg_hit[i] = cfg_valid & ~pend_vld_q[i];
            end
        end
    end

    // Divisor that takes effect at the next reload point.
    for (genvar g = 0; g < NCH; g++) begin : g_reload
        assign reload_div[g] = pend_vld_q[g] ? pend_q[g] : act_q[g];
    end

    always_comb begin
        cnt_d      = cnt_q;
        act_d      = act_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        clkout_d   = clkout;
        tick_d     = '0;
        for (int i = 0; i < NCH; i++) begin
            if (sync || !en[i]) begin
                // Held low and preloaded so the first rise lands act_div+1 cycles later.
                clkout_d[i]   = 1'b0;
                act_d[i]      = reload_div[i];
                cnt_d[i]      = reload_div[i];
                pend_vld_d[i] = 1'b0;
            end else if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end else begin
                clkout_d[i]   = ~clkout[i];
                tick_d[i]     = ~clkout[i];
                act_d[i]      = reload_div[i];
                cnt_d[i]      = reload_div[i];
                pend_vld_d[i] = 1'b0;
            end
            // Only reachable when nothing is pending, so it never races a promotion.
            if (cfg_hit[i]) begin
                pend_d[i]     = cfg_div;
                pend_vld_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]  <= DEF_DIV_V;
                act_q[i]  <= DEF_DIV_V;
                pend_q[i] <= '0;
            end
            pend_vld_q <= '0;
            clkout     <= '0;
            tick       <= '0;
        end else begin
            cnt_q      <= cnt_d;
            act_q      <= act_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            clkout     <= clkout_d;
            tick       <= tick_d;
        end
    end

endmodule

// File: tb/tb_multi_clk_gen.sv
// Bench for multi_clk_gen: directed scenarios plus random traffic, all checked against
// a half-period-countdown reference model of each channel.
module tb_multi_clk_gen;

    localparam int NCH     = 2;
    localparam int CW      = 16;
    localparam int DEF_DIV = 3;
    localparam int CHW     = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [NCH-1:0] en;
    logic           sync;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [CHW-1:0] cfg_ch;
    logic [CW-1:0]  cfg_div;
    logic [NCH-1:0] clkout;
    logic [NCH-1:0] tick;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: output level, tick, active divisor, cycles left in the
    // current half-period, and an optional pending divisor.
    bit m_lvl  [NCH];
    bit m_tk   [NCH];
    bit m_pend [NCH];
    int m_div  [NCH];
    int m_left [NCH];
    int m_pval [NCH];

    always #5 clk = ~clk;

    multi_clk_gen #(.NCH(NCH), .CW(CW), .DEF_DIV(DEF_DIV), .CHW(CHW)) dut (
        .clk(clk), .reset(reset), .en(en), .sync(sync),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .clkout(clkout), .tick(tick)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "time limit");
    end

    function automatic bit exp_ready(int ch);
        if (ch >= NCH) return 1'b1;
        return !m_pend[ch];
    endfunction

    // Advance one clk edge and update the model from the inputs seen at that edge.
    task automatic step();
        bit acc [NCH];
        @(posedge clk);
        for (int c = 0; c < NCH; c++) acc[c] = cfg_valid && (int'(cfg_ch) == c) && !m_pend[c];
        for (int c = 0; c < NCH; c++) begin
            if (reset) begin
                m_lvl[c] = 1'b0; m_tk[c] = 1'b0; m_pend[c] = 1'b0;
                m_div[c] = DEF_DIV; m_left[c] = DEF_DIV + 1;
            end else begin
                m_tk[c] = 1'b0;
                if (sync || !en[c]) begin
                    m_lvl[c] = 1'b0;
                    if (m_pend[c]) begin m_div[c] = m_pval[c]; m_pend[c] = 1'b0; end
                    m_left[c] = m_div[c] + 1;
                end else begin
                    m_left[c]--;
                    if (m_left[c] == 0) begin
                        m_lvl[c] = !m_lvl[c];
                        m_tk[c]  = m_lvl[c];
                        if (m_pend[c]) begin m_div[c] = m_pval[c]; m_pend[c] = 1'b0; end
                        m_left[c] = m_div[c] + 1;
                    end
                end
                if (acc[c]) begin m_pend[c] = 1'b1; m_pval[c] = int'(cfg_div); end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = '0; sync = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
        repeat (3) step();
        checks++;
        if (clkout !== 2'b00) begin errors++; $display("FAIL reset_clkout: got %b want 00", clkout); end
        checks++;
        if (tick !== 2'b00) begin errors++; $display("FAIL reset_tick: got %b want 00", tick); end
        for (int c = 0; c < NCH; c++) begin
            cfg_ch = CHW'(c); #1;
            checks++;
            if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready ch%0d: got %b want 1", c, cfg_ready); end
        end
        cfg_ch = '0;
    endtask

    task automatic test_reset_release();
        int first_rise = -1;
        int ticks = 0;
        int highs = 0;
        en = 2'b11; reset = 1'b0; cyc = 0;
        for (int k = 0; k < 24; k++) begin
            step();
            for (int c = 0; c < NCH; c++) begin
                checks++;
                if (clkout[c] !== m_lvl[c] || tick[c] !== m_tk[c]) begin
                    errors++;
                    $display("FAIL release ch%0d edge %0d: clkout=%b tick=%b want %b %b", c, cyc, clkout[c], tick[c], m_lvl[c], m_tk[c]);
                end
            end
            checks++;
            if (tick[0] !== ((cyc % 8) == 4)) begin
                errors++; $display("FAIL release_tick_pos edge %0d: tick0=%b want %b", cyc, tick[0], (cyc % 8) == 4);
            end
            if (clkout[0] === 1'b1 && first_rise < 0) first_rise = cyc;
            if (tick[0] === 1'b1) ticks++;
            if (clkout[0] === 1'b1) highs++;
        end
        checks++;
        if (first_rise != 4) begin errors++; $display("FAIL release_first_rise: got %0d want 4", first_rise); end
        checks++;
        if (ticks != 3) begin errors++; $display("FAIL release_tick_count: got %0d want 3", ticks); end
        checks++;
        if (highs != 12) begin errors++; $display("FAIL release_duty: high %0d of 24 want 12", highs); end
    endtask

    task automatic test_mid_period_write();
        int tog[$];
        int want[6] = '{28, 30, 32, 34, 36, 38};
        bit prev = clkout[0];
        for (int k = 0; k < 14; k++) begin
            if (k == 2) begin
                cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd1; #1;
                checks++;
                if (cfg_ready !== 1'b1) begin errors++; $display("FAIL mid_accept_ready: got %b want 1", cfg_ready); end
            end
            step();
            cfg_valid = 1'b0; #1;
            checks++;
            if (cfg_ready !== exp_ready(0)) begin
                errors++; $display("FAIL mid_ready edge %0d: got %b want %b", cyc, cfg_ready, exp_ready(0));
            end
            if (cyc == 27 || cyc == 28) begin
                checks++;
                if (cfg_ready !== (cyc == 28)) begin
                    errors++; $display("FAIL mid_ready_window edge %0d: got %b want %b", cyc, cfg_ready, cyc == 28);
                end
            end
            for (int c = 0; c < NCH; c++) begin
                checks++;
                if (clkout[c] !== m_lvl[c] || tick[c] !== m_tk[c]) begin
                    errors++;
                    $display("FAIL mid ch%0d edge %0d: clkout=%b tick=%b want %b %b", c, cyc, clkout[c], tick[c], m_lvl[c], m_tk[c]);
                end
            end
            checks++;
            if (clkout[1] !== (((cyc / 4) % 2) == 1)) begin
                errors++; $display("FAIL mid_ch1_undisturbed edge %0d: got %b want %b", cyc, clkout[1], ((cyc / 4) % 2) == 1);
            end
            if (clkout[0] !== prev) tog.push_back(cyc);
            prev = clkout[0];
        end
        checks++;
        if (tog.size() != 6) begin
            errors++; $display("FAIL mid_toggle_count: got %0d want 6", tog.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (tog[i] != want[i]) begin errors++; $display("FAIL mid_toggle_%0d: edge %0d want %0d", i, tog[i], want[i]); end
            end
        end
    endtask

    task automatic test_div_zero();
        int ticks = 0;
        bit prev = clkout[1];
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd0;
        for (int k = 0; k < 12; k++) begin
            step();
            cfg_valid = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                checks++;
                if (clkout[c] !== m_lvl[c] || tick[c] !== m_tk[c]) begin
                    errors++;
                    $display("FAIL div0 ch%0d edge %0d: clkout=%b tick=%b want %b %b", c, cyc, clkout[c], tick[c], m_lvl[c], m_tk[c]);
                end
            end
            if (k >= 4) begin
                checks++;
                if (clkout[1] === prev) begin errors++; $display("FAIL div0_toggle edge %0d: clkout1 stayed %b", cyc, prev); end
                if (tick[1] === 1'b1) ticks++;
            end
            prev = clkout[1];
        end
        checks++;
        if (ticks != 4) begin errors++; $display("FAIL div0_tick_count: got %0d want 4", ticks); end
    endtask

    task automatic test_enable();
        int rise_after = -1;
        en = 2'b10;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (clkout[0] !== 1'b0 || tick[0] !== 1'b0) begin
                errors++; $display("FAIL disabled edge %0d: clkout0=%b tick0=%b want 0 0", cyc, clkout[0], tick[0]);
            end
        end
        en = 2'b11;
        for (int k = 1; k <= 10 && rise_after < 0; k++) begin
            step();
            for (int c = 0; c < NCH; c++) begin
                checks++;
                if (clkout[c] !== m_lvl[c] || tick[c] !== m_tk[c]) begin
                    errors++;
                    $display("FAIL reenable ch%0d edge %0d: clkout=%b tick=%b want %b %b", c, cyc, clkout[c], tick[c], m_lvl[c], m_tk[c]);
                end
            end
            if (clkout[0] === 1'b1) rise_after = k;
        end
        checks++;
        if (rise_after != 2) begin errors++; $display("FAIL reenable_first_rise: got %0d want 2 (div 1)", rise_after); end
    endtask

    task automatic test_sync();
        int r0[$];
        int r1[$];
        int s;
        bit p0, p1;
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd3; #1;
        checks++;
        if (cfg_ready !== exp_ready(0)) begin errors++; $display("FAIL sync_cfg0_ready: got %b want %b", cfg_ready, exp_ready(0)); end
        step();
        cfg_ch = 2'd1; cfg_div = 16'd1; #1;
        checks++;
        if (cfg_ready !== exp_ready(1)) begin errors++; $display("FAIL sync_cfg1_ready: got %b want %b", cfg_ready, exp_ready(1)); end
        step();
        cfg_valid = 1'b0;
        repeat (10) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        s = cyc;
        checks++;
        if (clkout !== 2'b00 || tick !== 2'b00) begin
            errors++; $display("FAIL sync_clear: clkout=%b tick=%b want 00 00", clkout, tick);
        end
        p0 = 1'b0; p1 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step();
            for (int c = 0; c < NCH; c++) begin
                checks++;
                if (clkout[c] !== m_lvl[c] || tick[c] !== m_tk[c]) begin
                    errors++;
                    $display("FAIL sync ch%0d edge %0d: clkout=%b tick=%b want %b %b", c, cyc, clkout[c], tick[c], m_lvl[c], m_tk[c]);
                end
            end
            if (clkout[0] === 1'b1 && !p0) r0.push_back(cyc - s);
            if (clkout[1] === 1'b1 && !p1) r1.push_back(cyc - s);
            p0 = clkout[0]; p1 = clkout[1];
        end
        checks++;
        if (r0.size() != 2 || r0[0] != 4 || r0[1] != 12) begin
            errors++; $display("FAIL sync_ch0_rises: got %p want 4,12", r0);
        end
        checks++;
        if (r1.size() != 4 || r1[0] != 2 || r1[1] != 6 || r1[2] != 10 || r1[3] != 14) begin
            errors++; $display("FAIL sync_ch1_rises: got %p want 2,6,10,14", r1);
        end
    endtask

    task automatic test_out_of_range();
        int rises = 0;
        bit p0 = clkout[0];
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 16'd7; #1;
        checks++;
        if (cfg_ready !== 1'b1) begin errors++; $display("FAIL oor_ready: got %b want 1", cfg_ready); end
        step();
        cfg_valid = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            cfg_ch = CHW'(c); #1;
            checks++;
            if (cfg_ready !== 1'b1) begin errors++; $display("FAIL oor_no_pending ch%0d: got %b want 1", c, cfg_ready); end
        end
        for (int k = 0; k < 16; k++) begin
            step();
            for (int c = 0; c < NCH; c++) begin
                checks++;
                if (clkout[c] !== m_lvl[c] || tick[c] !== m_tk[c]) begin
                    errors++;
                    $display("FAIL oor ch%0d edge %0d: clkout=%b tick=%b want %b %b", c, cyc, clkout[c], tick[c], m_lvl[c], m_tk[c]);
                end
            end
            if (clkout[0] === 1'b1 && !p0) rises++;
            p0 = clkout[0];
        end
        checks++;
        if (rises != 2) begin errors++; $display("FAIL oor_ch0_period: %0d rises in 16 want 2", rises); end
    endtask

    task automatic test_reset_pending();
        int first_rise = -1;
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd9;
        step();
        cfg_valid = 1'b0; #1;
        checks++;
        if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rstpend_pending: ready %b want 0", cfg_ready); end
        reset = 1'b1;
        repeat (2) step();
        checks++;
        if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rstpend_cleared: ready %b want 1", cfg_ready); end
        checks++;
        if (clkout !== 2'b00) begin errors++; $display("FAIL rstpend_clkout: got %b want 00", clkout); end
        reset = 1'b0; cyc = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (clkout[0] === 1'b1 && first_rise < 0) first_rise = cyc;
        end
        checks++;
        if (first_rise != 4) begin errors++; $display("FAIL rstpend_def_div: first rise %0d want 4", first_rise); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            reset     = ($urandom_range(0, 499) == 0);
            sync      = ($urandom_range(0, 59) == 0);
            for (int c = 0; c < NCH; c++) en[c] = ($urandom_range(0, 15) != 0);
            cfg_valid = ($urandom_range(0, 2) == 0);
            cfg_ch    = CHW'($urandom_range(0, 3));
            cfg_div   = CW'($urandom_range(0, 6));
            #1;
            checks++;
            if (cfg_ready !== exp_ready(int'(cfg_ch))) begin
                errors++; $display("FAIL rand_ready cyc %0d ch%0d: got %b want %b", k, cfg_ch, cfg_ready, exp_ready(int'(cfg_ch)));
            end
            step();
            for (int c = 0; c < NCH; c++) begin
                checks++;
                if (clkout[c] !== m_lvl[c] || tick[c] !== m_tk[c]) begin
                    errors++;
                    $display("FAIL rand ch%0d cyc %0d: clkout=%b tick=%b want %b %b", c, k, clkout[c], tick[c], m_lvl[c], m_tk[c]);
                end
            end
        end
        reset = 1'b0; sync = 1'b0; cfg_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_reset_release();
        test_mid_period_write();
        test_div_zero();
        test_enable();
        test_sync();
        test_out_of_range();
        test_reset_pending();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
